clap_decoder: RTL and testbench
===============================

# clap_decoder

Sound-event front end for the microphone input. It synchronizes and glitch-filters the raw digital `mic` comparator output and turns each filtered rising edge into a clap event. It counts claps in a burst and, once the burst has been silent for a gap time, reports the count with a one-cycle valid strobe. The pet state logic consumes the count as a command, and the buzzer responder consumes the same count. A lockout period after each report keeps the buzzer's own response from retriggering the decoder.

## Interface
Parameters:
- `DEB_CYCLES`, 1_000_000: cycles `mic` must be stable before the filtered level changes (20 ms at 50 MHz); must be ≥1.
- `GAP_CYCLES`, 30_000_000: silence after the last clap that closes a burst (0.6 s); must be ≥1.
- `LOCKOUT_CYCLES`, 50_000_000: clap-blind time after a report (1 s); must be ≥1.

Ports:
- `clk` in 1: the one and only clock.
- `rst` in 1: asynchronous, active-low reset.
- `mic` in 1: raw microphone comparator output, asynchronous, high means sound.
- `en` in 1: decoder enable; low aborts any burst and suppresses events.
- `clap_pulse` out 1: one-cycle strobe per accepted clap.
- `clap_count` out 3: count of the last reported burst, 1..7, held between reports.
- `count_valid` out 1: one-cycle strobe when `clap_count` updates.
- `busy` out 1: high in COUNT or LOCKOUT.

## Operation
- **Reset values:** every output is 0, synchronizer and filtered level are 0, state is IDLE, all counters are 0. Reset mid-burst discards the burst and produces no report.
- **Synchronizer:** a 2-FF synchronizer on `mic` produces `mic_s`.
- **Filter counter:**
  - The counter increments on each cycle where `mic_s` differs from the filtered level `mic_f`, and clears when they match.
  - At terminal count `DEB_CYCLES-1` with a mismatch, `mic_f` takes `mic_s` and the counter clears.
  - Pulses shorter than `DEB_CYCLES` are ignored.
- **Clap event:** a filtered 0→1 transition. `clap_pulse` is registered and rises at the same edge as `mic_f`. The filter always runs; `clap_pulse` is suppressed when `en`=0 or the state is LOCKOUT.
- **IDLE:** on a clap, set count=1, timer=0, go to COUNT.
- **COUNT:**
  - The timer increments every cycle.
  - On a clap, the count increments (saturating at 7) and the timer clears.
  - At timer=`GAP_CYCLES-1` with no clap that cycle: `clap_count`←count, `count_valid`=1, timer=0, go to LOCKOUT.
  - A clap coinciding with the terminal count wins: the count increments, the timer restarts, and no report is made.
- **LOCKOUT:** the timer increments and claps are ignored. At timer=`LOCKOUT_CYCLES-1`, go to IDLE.
- **`en`=0:** force IDLE, clear count and timer. No report is made, `clap_count` keeps its last value, and `count_valid` stays 0.
- **Widths:** the timer is `$clog2(max(GAP_CYCLES,LOCKOUT_CYCLES))` bits. The count is 3 bits, saturating and never wrapping.

## Timing
- **Clap latency:** take the first edge at which the synchronizer's first flop samples `mic`=1 as edge 0. `mic_f` and `clap_pulse` then rise at edge `DEB_CYCLES+1`, provided `mic` stays high throughout.
- **Report latency:** `count_valid` is asserted exactly `GAP_CYCLES` cycles after the last `clap_pulse`, for exactly one cycle.
- **Strobe alignment:** `clap_count` changes only on the `count_valid` edge. `busy` falls `LOCKOUT_CYCLES` cycles after `count_valid`.
- **Re-arming:** the first clap accepted after lockout can arrive one cycle after `busy` falls.
- **Strobe exclusivity:** `clap_pulse` and `count_valid` are never high in the same cycle.

## Structure
- **Shared package `sensor_pkg`:**
  - state encoding: IDLE=0, COUNT=1, LOCKOUT=2, as a 2-bit enum;
  - `CLAP_W`=3 and `CLAP_MAX`=7, reused by the buzzer responder and the pet state logic.
- **Sub-module `debounce_filter`:** the synchronizer plus the stability counter, parameterized by `DEB_CYCLES`, with outputs `mic_f` and a rise strobe. Reusable for the board push-buttons.
- **Top level:** the clap-burst FSM and the shared gap/lockout timer.

## Test plan
All scenarios use `DEB_CYCLES`=4, `GAP_CYCLES`=20, `LOCKOUT_CYCLES`=10.
- **Glitch rejection:** a `mic` pulse 3 cycles long → no `clap_pulse`, `busy` stays 0. A 6-cycle pulse → one `clap_pulse` at edge 5 from its start.
- **Three-clap burst:** three 8-cycle pulses spaced 12 cycles apart → three `clap_pulse` strobes. One `count_valid` follows 20 cycles after the third, with `clap_count`=3. `busy` drops 10 cycles later.
- **Saturation:** nine claps in one burst → `clap_count`=7, single report.
- **Coincidence and lockout:** a clap landing exactly at timer=19 → no report, count increments, timer restarts. A clap during LOCKOUT → no `clap_pulse`, count unaffected. A clap immediately after LOCKOUT → new burst, count=1.
- **Enable and reset aborts:**
  - `en` low mid-burst → `busy`=0 next cycle, no `count_valid`, `clap_count` unchanged.
  - `rst` low mid-COUNT → all outputs 0 immediately, no report after release.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor front ends: clap-burst state encoding and
// clap-count width, also used by the buzzer responder and the pet state logic.
package sensor_pkg;

   localparam int unsigned CLAP_W   = 3;
   localparam int unsigned CLAP_MAX = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      LOCKOUT = 2'd2
   } clap_state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stability counter: the filtered level follows the
// input only after it has differed for DEB_CYCLES consecutive cycles.
module debounce_filter #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise_c
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             din_s;
   logic             term_c;

   assign din_s = sync[1];

   // term_c marks the edge at which the filtered level flips
   always_comb begin
      term_c = (din_s != level) && (cnt == CNT_TERM);
      rise_c = term_c && din_s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= 2'b00;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         if (term_c) begin
            level <= din_s;
            cnt   <= '0;
         end else if (din_s != level) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/clap_decoder.sv
// Clap-burst decoder: counts filtered mic rising edges in a burst, reports the
// count after a silent gap, then ignores claps for a lockout period.
module clap_decoder
   import sensor_pkg::*;
#(
   parameter int unsigned DEB_CYCLES     = 1_000_000,
   parameter int unsigned GAP_CYCLES     = 30_000_000,
   parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mic,
   input  logic              en,
   output logic              clap_pulse,
   output logic [CLAP_W-1:0] clap_count,
   output logic              count_valid,
   output logic              busy
);

   localparam int unsigned TIM_MAX = (GAP_CYCLES > LOCKOUT_CYCLES) ? GAP_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TIM_W   = (TIM_MAX > 1) ? $clog2(TIM_MAX) : 1;
   localparam logic [TIM_W-1:0] GAP_TERM  = TIM_W'(GAP_CYCLES - 1);
   localparam logic [TIM_W-1:0] LOCK_TERM = TIM_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CLAP_W-1:0] CNT_SAT  = CLAP_W'(CLAP_MAX);

   clap_state_e       state, state_nx;
   logic [CLAP_W-1:0] count, count_nx;
   logic [TIM_W-1:0]  timer, timer_nx;
   logic [CLAP_W-1:0] clap_count_nx;
   logic              count_valid_nx;
   logic              clap_pulse_nx;
   logic              busy_nx;
   logic              mic_f;
   logic              rise_c;
   logic              clap_c;

   debounce_filter #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .din    (mic),
      .level  (mic_f),
      .rise_c (rise_c)
   );

   // Accepted clap: filtered level about to rise, decoder enabled, not locked out
   always_comb begin
      clap_c = rise_c && !mic_f && en && (state != LOCKOUT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         timer       <= '0;
         clap_count  <= '0;
         count_valid <= 1'b0;
         clap_pulse  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         count       <= count_nx;
         timer       <= timer_nx;
         clap_count  <= clap_count_nx;
         count_valid <= count_valid_nx;
         clap_pulse  <= clap_pulse_nx;
         busy        <= busy_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      count_nx       = count;
      timer_nx       = timer;
      clap_count_nx  = clap_count;
      count_valid_nx = 1'b0;
      clap_pulse_nx  = clap_c;

      if (!en) begin
         state_nx = IDLE;
         count_nx = '0;
         timer_nx = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (clap_c) begin
                  state_nx = COUNT;
                  count_nx = CLAP_W'(1);
                  timer_nx = '0;
               end
            end
            COUNT: begin
               // a clap on the terminal cycle extends the burst instead of reporting
               if (clap_c) begin
                  count_nx = (count == CNT_SAT) ? count : count + CLAP_W'(1);
                  timer_nx = '0;
               end else if (timer == GAP_TERM) begin
                  clap_count_nx  = count;
                  count_valid_nx = 1'b1;
                  timer_nx       = '0;
                  state_nx       = LOCKOUT;
               end else begin
                  timer_nx = timer + TIM_W'(1);
               end
            end
            LOCKOUT: begin
               if (timer == LOCK_TERM) begin
                  timer_nx = '0;
                  state_nx = IDLE;
               end else begin
                  timer_nx = timer + TIM_W'(1);
               end
            end
            default: begin
               state_nx = IDLE;
               count_nx = '0;
               timer_nx = '0;
            end
         endcase
      end

      busy_nx = (state_nx != IDLE);
   end

endmodule

// File: tb/tb_clap_decoder.sv
// Self-checking bench for clap_decoder: event-time reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_clap_decoder;

   localparam int DEB  = 4;
   localparam int GAP  = 20;
   localparam int LOCK = 10;

   logic       clk;
   logic       rst;
   logic       mic;
   logic       en;
   logic       clap_pulse;
   logic [2:0] clap_count;
   logic       count_valid;
   logic       busy;

   int n_checks;
   int n_fail;

   clap_decoder #(
      .DEB_CYCLES    (DEB),
      .GAP_CYCLES    (GAP),
      .LOCKOUT_CYCLES(LOCK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mic        (mic),
      .en         (en),
      .clap_pulse (clap_pulse),
      .clap_count (clap_count),
      .count_valid(count_valid),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void check(string name, int actual, int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endfunction

   // Reference model: filter as "last DEB synchronized samples all disagree",
   // burst logic as absolute cycle stamps of the last clap and lockout end.
   bit   m_s1, m_s2, m_f;
   bit   hist [DEB];
   int   m_cyc, m_n, m_last, m_lock_end;
   bit   m_burst;
   bit   exp_pulse, exp_valid, exp_busy;
   int   exp_count;
   bit   ms, rise, all_diff, locked;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s1 = 0; m_s2 = 0; m_f = 0;
         for (int i = 0; i < DEB; i++) hist[i] = 0;
         m_cyc = 0; m_n = 0; m_last = 0; m_lock_end = 0; m_burst = 0;
         exp_pulse = 0; exp_valid = 0; exp_busy = 0; exp_count = 0;
      end else begin
         m_cyc++;
         ms = m_s2;
         for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = ms;
         all_diff = 1;
         for (int i = 0; i < DEB; i++) if (hist[i] == m_f) all_diff = 0;
         rise = 0;
         if (all_diff) begin
            rise = ms;
            m_f  = ms;
         end
         m_s2 = m_s1;
         m_s1 = mic;

         exp_pulse = 0;
         exp_valid = 0;
         if (!en) begin
            m_burst    = 0;
            m_n        = 0;
            m_lock_end = 0;
         end else begin
            locked = (m_cyc <= m_lock_end);
            if (rise && !locked) begin
               exp_pulse = 1;
               m_n       = m_burst ? ((m_n < 7) ? m_n + 1 : 7) : 1;
               m_burst   = 1;
               m_last    = m_cyc;
            end else if (m_burst && m_cyc == m_last + GAP) begin
               exp_valid  = 1;
               exp_count  = m_n;
               m_burst    = 0;
               m_lock_end = m_cyc + LOCK;
            end
         end
         exp_busy = m_burst || (m_cyc < m_lock_end);
      end
   end

   // Per-cycle compare plus event stamps for the directed checks
   int ncyc, n_pulse, n_valid, last_pulse, last_valid, last_busy_fall;
   bit busy_prev;

   always @(posedge clk) begin
      #1;
      ncyc++;
      check("clap_pulse", clap_pulse, exp_pulse);
      check("count_valid", count_valid, exp_valid);
      check("clap_count", clap_count, exp_count);
      check("busy", busy, exp_busy);
      check("strobe_excl", clap_pulse & count_valid, 0);
      if (clap_pulse) begin n_pulse++; last_pulse = ncyc; end
      if (count_valid) begin n_valid++; last_valid = ncyc; end
      if (busy_prev && !busy) last_busy_fall = ncyc;
      busy_prev = busy;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      mic = 1'b1;
      cycles(hi);
      mic = 1'b0;
      cycles(lo);
   endtask

   task automatic wait_valid(input int limit);
      int k;
      k = 0;
      while (!count_valid && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("valid_seen", count_valid, 1);
   endtask

   int p0, v0;

   initial begin
      n_checks = 0; n_fail = 0;
      ncyc = 0; n_pulse = 0; n_valid = 0; busy_prev = 0;
      last_pulse = 0; last_valid = 0; last_busy_fall = 0;
      rst = 1'b0; mic = 1'b0; en = 1'b1;
      cycles(3);
      check("rst_pulse", clap_pulse, 0);
      check("rst_count", clap_count, 0);
      check("rst_valid", count_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      cycles(2);

      // Glitch shorter than DEB is ignored
      p0 = n_pulse;
      pulse(3, 15);
      check("glitch_pulses", n_pulse - p0, 0);
      check("glitch_busy", busy, 0);

      // 6-cycle pulse: clap strobe after edge 5 counted from the first sample
      mic = 1'b1;
      cycles(5);
      check("lat_edge4", clap_pulse, 0);
      cycles(1);
      check("lat_edge5", clap_pulse, 1);
      mic = 1'b0;
      cycles(45);
      check("single_count", clap_count, 1);

      // Three claps 20 cycles apart: middle ones land on the terminal timer cycle
      p0 = n_pulse; v0 = n_valid;
      for (int i = 0; i < 3; i++) pulse(8, 12);
      cycles(30);
      check("burst3_pulses", n_pulse - p0, 3);
      check("burst3_reports", n_valid - v0, 1);
      check("burst3_count", clap_count, 3);
      check("burst3_gap", last_valid - last_pulse, GAP);
      check("burst3_lockout", last_busy_fall - last_valid, LOCK);

      // Nine claps saturate at seven
      p0 = n_pulse; v0 = n_valid;
      for (int i = 0; i < 9; i++) pulse(6, 8);
      cycles(45);
      check("sat_pulses", n_pulse - p0, 9);
      check("sat_reports", n_valid - v0, 1);
      check("sat_count", clap_count, 7);

      // Clap during lockout is ignored; the next one starts a fresh burst
      pulse(6, 0);
      wait_valid(60);
      p0 = n_pulse; v0 = n_valid;
      pulse(4, 5);
      pulse(6, 45);
      check("lock_pulses", n_pulse - p0, 1);
      check("lock_reports", n_valid - v0, 1);
      check("lock_newcount", clap_count, 1);

      // Enable drop mid-burst
      v0 = n_valid;
      pulse(6, 4);
      check("en_busy_before", busy, 1);
      en = 1'b0;
      cycles(1);
      check("en_busy_after", busy, 0);
      cycles(40);
      check("en_reports", n_valid - v0, 0);
      check("en_count_kept", clap_count, 1);
      en = 1'b1;
      cycles(2);

      // Asynchronous reset mid-burst
      v0 = n_valid;
      pulse(6, 3);
      check("rst_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      check("arst_pulse", clap_pulse, 0);
      check("arst_count", clap_count, 0);
      check("arst_valid", count_valid, 0);
      check("arst_busy", busy, 0);
      cycles(1);
      rst = 1'b1;
      cycles(40);
      check("arst_reports", n_valid - v0, 0);
      check("arst_count_after", clap_count, 0);

      // Random mic activity with occasional enable drops
      for (int i = 0; i < 150; i++) begin
         en = ($urandom_range(0, 11) != 0);
         pulse($urandom_range(1, 9), $urandom_range(1, 30));
      end
      en = 1'b1;
      cycles(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
